// File: rtl/si5340_i2c_master.sv
// Single-master I2C byte engine: one command per handshake runs an optional
// START, one byte write or read, and an optional STOP, honouring slave clock stretching.
module si5340_i2c_master #(
  parameter int CLK_FREQ_HZ = 125000000,
  parameter int I2C_FREQ_HZ = 400000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_start_i,
  input  logic       cmd_stop_i,
  input  logic       cmd_write_i,
  input  logic       cmd_read_i,
  input  logic       cmd_nack_i,
  input  logic [7:0] cmd_data_i,
  output logic       done_o,
  output logic       ack_o,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  input  logic       scl_pad_i,
  output logic       scl_pad_o,
  output logic       scl_padoen_o,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o
);

  localparam int QUARTER = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
  localparam int QW = (QUARTER > 2) ? $clog2(QUARTER) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(QUARTER - 1);

  if (QUARTER < 2) begin : g_quarter_check
    $error("si5340_i2c_master: CLK_FREQ_HZ/(4*I2C_FREQ_HZ) must be at least 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_WRITE, S_READ, S_STOP, S_DONE} state_t;
  typedef enum logic [1:0] {Q_A, Q_B, Q_C, Q_D} quarter_t;

  state_t        state, state_n;
  quarter_t      phase, phase_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    rx_data, rx_data_n;
  logic          c_stop, c_write, c_read, c_nack;
  logic          scl_oen, scl_oen_n, sda_oen, sda_oen_n;
  logic          busy, busy_n, ack, ack_n;
  logic          accept, active, stretch, tick;

  // Remaining phases of a command, in bus order; write takes precedence over read.
  function automatic state_t next_of(logic s, logic w, logic r, logic p);
    if (s) return S_START;
    if (w) return S_WRITE;
    if (r) return S_READ;
    if (p) return S_STOP;
    return S_DONE;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_n   = state;
    phase_n   = phase;
    qcnt_n    = qcnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    rx_data_n = rx_data;
    busy_n    = busy;
    ack_n     = ack;
    accept    = 1'b0;
    active    = state inside {S_START, S_WRITE, S_READ, S_STOP};
    // A released SCL still read low means the slave is stretching: freeze at count 0.
    stretch   = scl_oen && !scl_pad_i && (qcnt == '0);
    tick      = active && !stretch && (qcnt == Q_LAST);
    if (active && !stretch) qcnt_n = tick ? '0 : qcnt + 1'b1;

    case (state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          accept    = 1'b1;
          state_n   = next_of(cmd_start_i, cmd_write_i, cmd_read_i, cmd_stop_i);
          phase_n   = Q_A;
          bit_cnt_n = '0;
          shreg_n   = cmd_data_i;
        end
      end
      S_START: begin
        if (tick) begin
          phase_n = quarter_t'(phase + 2'd1);
          if (phase == Q_C) busy_n = 1'b1;
          if (phase == Q_D) state_n = next_of(1'b0, c_write, c_read, c_stop);
        end
      end
      S_WRITE, S_READ: begin
        if (tick) begin
          phase_n = quarter_t'(phase + 2'd1);
          if (phase == Q_C) begin
            if (bit_cnt == 4'd8) begin
              if (state == S_WRITE) ack_n = sda_pad_i;
            end else if (state == S_READ) begin
              shreg_n = {shreg[6:0], sda_pad_i};
            end
          end
          if (phase == Q_D) begin
            if (bit_cnt == 4'd8) begin
              bit_cnt_n = '0;
              state_n   = next_of(1'b0, 1'b0, 1'b0, c_stop);
            end else begin
              bit_cnt_n = bit_cnt + 4'd1;
              if (state == S_WRITE) shreg_n = {shreg[6:0], 1'b0};
            end
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          phase_n = quarter_t'(phase + 2'd1);
          if (phase == Q_C) busy_n = 1'b0;
          if (phase == Q_D) state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (state_n == S_DONE && (state == S_READ || state == S_STOP) && c_read) rx_data_n = shreg;

    // Pad enables follow the quarter being entered, so they change together with the phase.
    scl_oen_n = scl_oen;
    sda_oen_n = sda_oen;
    case (state_n)
      S_START: begin
        case (phase_n)
          Q_A: sda_oen_n = 1'b1;
          Q_B: scl_oen_n = 1'b1;
          Q_C: sda_oen_n = 1'b0;
          Q_D: scl_oen_n = 1'b0;
          default: ;
        endcase
      end
      S_WRITE, S_READ: begin
        case (phase_n)
          Q_A: begin
            scl_oen_n = 1'b0;
            if (bit_cnt_n == 4'd8) sda_oen_n = (state_n == S_WRITE) ? 1'b1 : c_nack;
            else                   sda_oen_n = (state_n == S_WRITE) ? shreg_n[7] : 1'b1;
          end
          Q_B:     scl_oen_n = 1'b1;
          Q_D:     scl_oen_n = 1'b0;
          default: ;
        endcase
      end
      S_STOP: begin
        case (phase_n)
          Q_A:     sda_oen_n = 1'b0;
          Q_B:     scl_oen_n = 1'b1;
          Q_C:     sda_oen_n = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      phase   <= Q_A;
      qcnt    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rx_data <= '0;
      c_stop  <= 1'b0;
      c_write <= 1'b0;
      c_read  <= 1'b0;
      c_nack  <= 1'b0;
      scl_oen <= 1'b1;
      sda_oen <= 1'b1;
      busy    <= 1'b0;
      ack     <= 1'b0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      qcnt    <= qcnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      rx_data <= rx_data_n;
      scl_oen <= scl_oen_n;
      sda_oen <= sda_oen_n;
      busy    <= busy_n;
      ack     <= ack_n;
      if (accept) begin
        c_stop  <= cmd_stop_i;
        c_write <= cmd_write_i;
        c_read  <= cmd_read_i && !cmd_write_i;
        c_nack  <= cmd_nack_i;
      end
    end
  end

  assign cmd_ready_o  = (state == S_IDLE);
  assign done_o       = (state == S_DONE);
  assign ack_o        = ack;
  assign rx_data_o    = rx_data;
  assign busy_o       = busy;
  assign scl_pad_o    = 1'b0;
  assign sda_pad_o    = 1'b0;
  assign scl_padoen_o = scl_oen;
  assign sda_padoen_o = sda_oen;

endmodule

// File: tb/tb_si5340_i2c_master.sv
// Scoreboard bench for si5340_i2c_master: directed commands against a small I2C slave
// model on open-drain pads; a monitor checks every done_o against queued expectations.
module tb_si5340_i2c_master;

  typedef enum int {M_NONE, M_ACK, M_TX} slave_mode_t;

  typedef struct {
    int         tag;
    logic       chk_ack;
    logic       ack;
    logic       chk_rx;
    logic [7:0] rx;
    int         lat;
    int         acc_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_start_i = 1'b0;
  logic       cmd_stop_i = 1'b0;
  logic       cmd_write_i = 1'b0;
  logic       cmd_read_i = 1'b0;
  logic       cmd_nack_i = 1'b0;
  logic [7:0] cmd_data_i = 8'h00;
  logic       cmd_ready_o, done_o, ack_o, busy_o;
  logic [7:0] rx_data_o;
  logic       scl_pad_i, scl_pad_o, scl_padoen_o;
  logic       sda_pad_i, sda_pad_o, sda_padoen_o;

  // Slave model state
  slave_mode_t slave_mode = M_NONE;
  logic [7:0]  tx_byte = 8'h00;
  int          stretch_req = 0;
  int          stretch_taken = 0;
  int          stretch_cnt = 0;
  logic        slave_scl_low = 1'b0;
  logic        slave_sda;
  int          bitpos = -1;
  logic        rd_armed = 1'b0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic [7:0]  rx_shift = 8'h00;
  logic [7:0]  last_byte = 8'h00;
  int          byte_cnt = 0;
  int          stop_cnt = 0;
  logic        ninth_sda = 1'b0;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;
  exp_t sb_q[$];

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign scl_pad_i = scl_padoen_o & ~slave_scl_low;
  assign sda_pad_i = sda_padoen_o & slave_sda;

  si5340_i2c_master dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_start_i  (cmd_start_i),
    .cmd_stop_i   (cmd_stop_i),
    .cmd_write_i  (cmd_write_i),
    .cmd_read_i   (cmd_read_i),
    .cmd_nack_i   (cmd_nack_i),
    .cmd_data_i   (cmd_data_i),
    .done_o       (done_o),
    .ack_o        (ack_o),
    .rx_data_o    (rx_data_o),
    .busy_o       (busy_o),
    .scl_pad_i    (scl_pad_i),
    .scl_pad_o    (scl_pad_o),
    .scl_padoen_o (scl_padoen_o),
    .sda_pad_i    (sda_pad_i),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Slave drives SDA low for the ACK slot, or shifts out tx_byte after a START.
  always_comb begin
    slave_sda = 1'b1;
    if (slave_mode == M_ACK && bitpos == 8) slave_sda = 1'b0;
    if (slave_mode == M_TX && rd_armed && bitpos >= 0 && bitpos <= 7) slave_sda = tx_byte[7-bitpos];
  end

  // Bit position: -1 after START, 0..7 data, 8 the ACK slot; wraps to 0 after the ACK slot.
  always @(negedge clk) begin
    if (rst_i) begin
      bitpos        = -1;
      rd_armed      = 1'b0;
      prev_scl      = 1'b1;
      prev_sda      = 1'b1;
      slave_scl_low = 1'b0;
      stretch_cnt   = 0;
    end else begin
      if (prev_scl && scl_pad_i && prev_sda && !sda_pad_i) begin
        bitpos   = -1;
        rd_armed = 1'b1;
      end
      if (prev_scl && scl_pad_i && !prev_sda && sda_pad_i) stop_cnt++;
      if (!prev_scl && scl_pad_i) begin
        if (bitpos >= 0 && bitpos <= 7) rx_shift = {rx_shift[6:0], sda_pad_i};
        else if (bitpos == 8)           ninth_sda = sda_pad_i;
      end
      if (prev_scl && !scl_pad_i) begin
        if (bitpos == 8) begin
          last_byte = rx_shift;
          byte_cnt++;
          bitpos    = 0;
          rd_armed  = 1'b0;
        end else begin
          bitpos++;
        end
      end
      if (stretch_req != stretch_taken && bitpos == 2 && !scl_pad_i && !slave_scl_low) begin
        slave_scl_low = 1'b1;
        stretch_cnt   = 0;
        stretch_taken++;
      end else if (slave_scl_low && scl_padoen_o) begin
        // Released after 50 cycles of the master waiting on the high phase.
        if (stretch_cnt == 50) slave_scl_low = 1'b0;
        else                   stretch_cnt++;
      end
      prev_scl = scl_pad_i;
      prev_sda = sda_pad_i;
    end
  end

  // Monitor: every done_o pulse is matched against the oldest outstanding command.
  always @(negedge clk) begin
    if (!rst_i && done_o) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("cmd%0d_latency", e.tag), cyc - e.acc_cyc, e.lat);
        if (e.chk_ack) check($sformatf("cmd%0d_ack", e.tag), int'(ack_o), int'(e.ack));
        if (e.chk_rx)  check($sformatf("cmd%0d_rx_data", e.tag), int'(rx_data_o), int'(e.rx));
      end
    end
  end

  task automatic issue(input int tag, input logic s, input logic w, input logic r,
                       input logic p, input logic n, input logic [7:0] d,
                       input logic chk_ack, input logic exp_ack,
                       input logic chk_rx, input logic [7:0] exp_rx, input int exp_lat);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (!cmd_ready_o && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready_o) check($sformatf("cmd%0d_ready_timeout", tag), int'(cmd_ready_o), 1);
    cmd_start_i = s;
    cmd_write_i = w;
    cmd_read_i  = r;
    cmd_stop_i  = p;
    cmd_nack_i  = n;
    cmd_data_i  = d;
    cmd_valid_i = 1'b1;
    e.tag = tag; e.chk_ack = chk_ack; e.ack = exp_ack; e.chk_rx = chk_rx;
    e.rx = exp_rx; e.lat = exp_lat; e.acc_cyc = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int tag, input int budget);
    int t = 0;
    while ((sb_q.size() != 0 || !cmd_ready_o) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0 || !cmd_ready_o) begin
      check($sformatf("cmd%0d_done_timeout", tag), sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  initial begin
    int bytes0, stops0, done0;

    // Reset, then 20 idle cycles: bus released, engine ready, no done_o.
    repeat (4) @(negedge clk);
    rst_i = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_scl_padoen", int'(scl_padoen_o), 1);
    check("idle_sda_padoen", int'(sda_padoen_o), 1);
    check("idle_ready", int'(cmd_ready_o), 1);
    check("idle_busy", int'(busy_o), 0);
    check("idle_ack", int'(ack_o), 0);
    check("idle_rx_data", int'(rx_data_o), 0);
    check("idle_no_done", n_done, 0);

    // START + write 0xD0 to an acking slave, no STOP: 312 + 2808 + 1 cycles.
    slave_mode = M_ACK;
    bytes0 = byte_cnt;
    issue(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hD0, 1'b1, 1'b0, 1'b0, 8'h00, 3121);
    wait_idle(1, 5000);
    check("cmd1_bus_bits", int'(last_byte), 8'hD0);
    check("cmd1_byte_count", byte_cnt - bytes0, 1);
    check("cmd1_busy_held", int'(busy_o), 1);
    check("cmd1_scl_held_low", int'(scl_padoen_o), 0);

    // Repeated START + write 0xD0 with nobody answering, then STOP.
    slave_mode = M_NONE;
    stops0 = stop_cnt;
    issue(2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hD0, 1'b1, 1'b1, 1'b0, 8'h00, 3433);
    wait_idle(2, 5000);
    check("cmd2_stop_seen", stop_cnt - stops0, 1);
    check("cmd2_busy_cleared", int'(busy_o), 0);
    check("cmd2_scl_released", int'(scl_padoen_o), 1);
    check("cmd2_sda_released", int'(sda_padoen_o), 1);

    // START + read with NACK and STOP; slave returns 0xA5.
    slave_mode = M_TX;
    tx_byte    = 8'hA5;
    issue(3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 3433);
    wait_idle(3, 5000);
    check("cmd3_ninth_sda_released", int'(ninth_sda), 1);
    check("cmd3_busy_cleared", int'(busy_o), 0);

    // START + write 0x3C with a 50-cycle stretch on the 3rd bit's high phase.
    slave_mode  = M_ACK;
    stretch_req = 1;
    bytes0      = byte_cnt;
    issue(4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 3171);
    wait_idle(4, 5000);
    check("cmd4_stretch_applied", stretch_taken, 1);
    check("cmd4_bus_bits", int'(last_byte), 8'h3C);
    check("cmd4_rx_data_held", int'(rx_data_o), 8'hA5);

    // Empty command: done_o the cycle after accept, bus stays owned.
    issue(5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1);
    wait_idle(5, 100);
    check("cmd5_busy_held", int'(busy_o), 1);

    // Write and read both set: the write 0x81 runs, then STOP.
    bytes0 = byte_cnt;
    issue(6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0, 8'h00, 3121);
    wait_idle(6, 5000);
    check("cmd6_bus_bits", int'(last_byte), 8'h81);
    check("cmd6_byte_count", byte_cnt - bytes0, 1);
    check("cmd6_busy_cleared", int'(busy_o), 0);

    // Reset in the middle of a write byte: bus released at once, no done_o.
    issue(7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 3433);
    repeat (1500) @(negedge clk);
    done0 = n_done;
    rst_i = 1'b1;
    @(negedge clk);
    sb_q.delete();
    check("rst_scl_padoen", int'(scl_padoen_o), 1);
    check("rst_sda_padoen", int'(sda_padoen_o), 1);
    check("rst_ready", int'(cmd_ready_o), 1);
    check("rst_busy", int'(busy_o), 0);
    rst_i = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_done", n_done - done0, 0);

    // Fresh START + write 0x96 + STOP after the abort.
    bytes0 = byte_cnt;
    issue(8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h96, 1'b1, 1'b0, 1'b0, 8'h00, 3433);
    wait_idle(8, 5000);
    check("cmd8_bus_bits", int'(last_byte), 8'h96);
    check("cmd8_byte_count", byte_cnt - bytes0, 1);
    check("cmd8_busy_cleared", int'(busy_o), 0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
